// File: rtl/partial_boundary_driver.sv
// Replays buffered boundary vectors onto a partial circuit's lifted inputs and checks its outputs.
// Optional per-bit don't-care masking is enabled by defining PARTIAL_BOUNDARY_MASK_EN.
module partial_boundary_driver #(
  parameter int N_LIFT = 2,
  parameter int N_OUT  = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [N_LIFT-1:0] vec_lift,
  input  logic [N_OUT-1:0]  vec_exp,
`ifdef PARTIAL_BOUNDARY_MASK_EN
  input  logic [N_OUT-1:0]  vec_mask,
`endif
  input  logic              start,
  output logic [N_LIFT-1:0] lifted_out,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  vec_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [N_LIFT-1:0] lift;
    logic [N_OUT-1:0]  exp;
`ifdef PARTIAL_BOUNDARY_MASK_EN
    logic [N_OUT-1:0]  mask;
`endif
  } entry_t;

  state_t            state;
  entry_t            mem [DEPTH];
  entry_t            wr_entry;
  entry_t            head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ;
  logic [N_OUT-1:0]  exp_q;
`ifdef PARTIAL_BOUNDARY_MASK_EN
  logic [N_OUT-1:0]  mask_q;
`endif
  logic              cmp_pending;
  logic [N_OUT-1:0]  diff;
  logic              empty;
  logic              wr_en;
  logic              fail;

  assign empty     = (occ == '0);
  assign vec_ready = (state == IDLE) && (occ != FULL_OCC);
  assign wr_en     = vec_valid && vec_ready;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign head      = mem[rd_ptr];

  always_comb begin
    // NOTE: every always_comb output gets a value on the first line, so no latch can be inferred.
    wr_entry      = '0;
    wr_entry.lift = vec_lift;
    wr_entry.exp  = vec_exp;
`ifdef PARTIAL_BOUNDARY_MASK_EN
    wr_entry.mask = vec_mask;
`endif
  end

  always_comb begin
    diff = dut_out ^ exp_q;
`ifdef PARTIAL_BOUNDARY_MASK_EN
    diff = diff & ~mask_q;
`endif
  end

  assign fail = cmp_pending && (diff != '0);

  // NOTE: vector storage is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      lifted_out    <= '0;
      exp_q         <= '0;
`ifdef PARTIAL_BOUNDARY_MASK_EN
      mask_q        <= '0;
`endif
      cmp_pending   <= 1'b0;
      mismatch      <= 1'b0;
      err_count     <= '0;
      vec_count     <= '0;
      first_err_idx <= '1;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            occ    <= occ + OCC_ONE;
          end
          // Start decision looks at occupancy before any same-cycle write.
          if (start) state <= empty ? DONE : RUN;
        end
        RUN: begin
          if (!empty) begin
            lifted_out <= head.lift;
            exp_q      <= head.exp;
`ifdef PARTIAL_BOUNDARY_MASK_EN
            mask_q     <= head.mask;
`endif
            rd_ptr     <= rd_ptr + PTR_ONE;
            occ        <= occ - OCC_ONE;
          end
          cmp_pending <= !empty;
          if (cmp_pending) begin
            if (vec_count != '1) vec_count <= vec_count + CNT_W'(1);
            if (fail) begin
              mismatch <= 1'b1;
              if (err_count != '1)     err_count     <= err_count + CNT_W'(1);
              if (first_err_idx == '1) first_err_idx <= vec_count;
            end
          end
          // Buffer drained: this cycle carried the final compare.
          if (empty) state <= DONE;
        end
        DONE: begin
          if (start) begin
            err_count     <= '0;
            vec_count     <= '0;
            first_err_idx <= '1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_partial_boundary_driver.sv
// Randomized bench for partial_boundary_driver against a vector-list reference model.
// Define PARTIAL_BOUNDARY_MASK_EN for both files to exercise the masked compare.
module tb_partial_boundary_driver;

  localparam int N_LIFT = 2;
  localparam int N_OUT  = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [1:0] lift;
    logic [3:0] exp;
    logic [3:0] mask;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       vec_valid = 1'b0;
  logic       start = 1'b0;
  logic [1:0] vec_lift = '0;
  logic [3:0] vec_exp = '0;
`ifdef PARTIAL_BOUNDARY_MASK_EN
  logic [3:0] vec_mask = '0;
`endif
  logic       vec_ready, busy, done, mismatch;
  logic [1:0] lifted_out;
  logic [3:0] dut_out;
  logic [7:0] err_count, first_err_idx, vec_count;

  int   total = 0;
  int   fails = 0;
  vec_t q[$];

  partial_boundary_driver #(
    .N_LIFT(N_LIFT), .N_OUT(N_OUT), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_lift(vec_lift), .vec_exp(vec_exp),
`ifdef PARTIAL_BOUNDARY_MASK_EN
    .vec_mask(vec_mask),
`endif
    .start(start), .lifted_out(lifted_out), .dut_out(dut_out),
    .busy(busy), .done(done), .mismatch(mismatch),
    .err_count(err_count), .first_err_idx(first_err_idx), .vec_count(vec_count)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the extracted partial: a fixed combinational function of its lifted inputs.
  function automatic logic [3:0] golden(input logic [1:0] l);
    return {l[1] & l[0], l[1] | l[0], l[1] ^ l[0], ~l[0]};
  endfunction

  assign dut_out = golden(lifted_out);

  function automatic bit is_bad(input vec_t v);
    logic [3:0] m;
    m = 4'b0000;
`ifdef PARTIAL_BOUNDARY_MASK_EN
    m = v.mask;
`endif
    return ((golden(v.lift) ^ v.exp) & ~m) != 4'b0000;
  endfunction

  function automatic vec_t rand_vec(input bit corrupt);
    vec_t v;
    v.lift = 2'($urandom);
    v.exp  = golden(v.lift);
    if (corrupt) v.exp = v.exp ^ (4'b0001 << $urandom_range(0, 3));
    v.mask = 4'b0000;
    return v;
  endfunction

  task automatic load(input vec_t v);
    @(negedge CLK);
    vec_valid = 1'b1;
    vec_lift  = v.lift;
    vec_exp   = v.exp;
`ifdef PARTIAL_BOUNDARY_MASK_EN
    vec_mask  = v.mask;
`endif
    @(posedge CLK);
    #1 vec_valid = 1'b0;
    q.push_back(v);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // Replays the model's queue and checks every cycle of the run plus the final status.
  task automatic run_check(input string name);
    int         n;
    int         exp_err;
    logic [7:0] exp_first;
    bit         bad[$];
    bit         exp_m;
    n = q.size();
    exp_err = 0;
    exp_first = 8'hFF;
    foreach (q[i]) begin
      bad.push_back(is_bad(q[i]));
      if (bad[i]) begin
        exp_err++;
        if (exp_first == 8'hFF) exp_first = 8'(i);
      end
    end
    pulse_start();
    if (n == 0) begin
      total++; if (done !== 1'b1) begin fails++; $display("FAIL %s empty done: got %b want 1", name, done); end
      total++; if (vec_count !== 8'd0) begin fails++; $display("FAIL %s empty vec_count: got %0d want 0", name, vec_count); end
      total++; if (busy !== 1'b0) begin fails++; $display("FAIL %s empty busy: got %b want 0", name, busy); end
      return;
    end
    total++; if (busy !== 1'b1) begin fails++; $display("FAIL %s busy after start: got %b want 1", name, busy); end
    for (int t = 1; t <= n + 1; t++) begin
      @(posedge CLK);
      #1;
      if (t <= n) begin
        total++;
        if (lifted_out !== q[t-1].lift) begin
          fails++; $display("FAIL %s lifted_out t=%0d: got %b want %b", name, t, lifted_out, q[t-1].lift);
        end
      end
      exp_m = (t >= 2) ? bad[t-2] : 1'b0;
      total++; if (mismatch !== exp_m) begin fails++; $display("FAIL %s mismatch t=%0d: got %b want %b", name, t, mismatch, exp_m); end
      total++; if (done !== (t == n + 1)) begin fails++; $display("FAIL %s done t=%0d: got %b want %b", name, t, done, t == n + 1); end
    end
    total++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL %s err_count: got %0d want %0d", name, err_count, exp_err); end
    total++; if (first_err_idx !== exp_first) begin fails++; $display("FAIL %s first_err_idx: got %0d want %0d", name, first_err_idx, exp_first); end
    total++; if (vec_count !== 8'(n)) begin fails++; $display("FAIL %s vec_count: got %0d want %0d", name, vec_count, n); end
    @(posedge CLK);
    #1;
    total++; if (lifted_out !== q[n-1].lift) begin fails++; $display("FAIL %s lifted_out hold: got %b want %b", name, lifted_out, q[n-1].lift); end
    total++; if (mismatch !== 1'b0) begin fails++; $display("FAIL %s mismatch after done: got %b want 0", name, mismatch); end
    q.delete();
  endtask

  task automatic leave_done(input string name);
    pulse_start();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL %s idle state: got done=%b busy=%b want 0/0", name, done, busy); end
    total++; if (first_err_idx !== 8'hFF) begin fails++; $display("FAIL %s first_err_idx clear: got %h want ff", name, first_err_idx); end
    total++; if (err_count !== 8'd0 || vec_count !== 8'd0) begin fails++; $display("FAIL %s counters clear: got %0d/%0d want 0/0", name, err_count, vec_count); end
    total++; if (vec_ready !== 1'b1) begin fails++; $display("FAIL %s vec_ready in idle: got %b want 1", name, vec_ready); end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (lifted_out !== 2'b00) begin fails++; $display("FAIL reset lifted_out: got %b want 00", lifted_out); end
    total++; if ({busy, done, mismatch} !== 3'b000) begin fails++; $display("FAIL reset status: got %b want 000", {busy, done, mismatch}); end
    total++; if (err_count !== 8'd0 || vec_count !== 8'd0) begin fails++; $display("FAIL reset counters: got %0d/%0d want 0/0", err_count, vec_count); end
    total++; if (first_err_idx !== 8'hFF) begin fails++; $display("FAIL reset first_err_idx: got %h want ff", first_err_idx); end
    total++; if (vec_ready !== 1'b1) begin fails++; $display("FAIL reset vec_ready: got %b want 1", vec_ready); end
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  task automatic test_basic();
    vec_t v;
    for (int i = 0; i < 3; i++) begin
      v.lift = 2'(i);
      v.exp  = golden(v.lift);
      v.mask = 4'b0000;
      load(v);
    end
    run_check("basic");
    leave_done("basic");
  endtask

  task automatic test_error();
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v = rand_vec(1'b0);
      if (i == 2) v.exp = v.exp ^ 4'b0001;
      load(v);
    end
    run_check("error");
    leave_done("error");
  endtask

  task automatic test_full_wrap();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == DEPTH - 1) begin
          total++; if (vec_ready !== 1'b1) begin fails++; $display("FAIL full ready before last: got %b want 1", vec_ready); end
        end
        load(rand_vec($urandom_range(0, 3) == 0));
      end
      total++; if (vec_ready !== 1'b0) begin fails++; $display("FAIL full ready after %0d: got %b want 0", DEPTH, vec_ready); end
      @(negedge CLK);
      vec_valid = 1'b1;
      vec_lift  = 2'($urandom);
      vec_exp   = 4'($urandom);
      @(posedge CLK);
      #1 vec_valid = 1'b0;
      total++; if (vec_ready !== 1'b0) begin fails++; $display("FAIL full extra ready: got %b want 0", vec_ready); end
      run_check("full_wrap");
      leave_done("full_wrap");
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = rand_vec(i == 2);
      load(v);
    end
    pulse_start();
    repeat (3) @(posedge CLK);
    #1;
    total++; if (vec_count !== 8'd2) begin fails++; $display("FAIL midreset compares before reset: got %0d want 2", vec_count); end
    @(negedge CLK);
    RESETN = 1'b0;
    @(posedge CLK);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset state: got busy=%b done=%b want 0/0", busy, done); end
    total++; if (lifted_out !== 2'b00) begin fails++; $display("FAIL midreset lifted_out: got %b want 00", lifted_out); end
    total++; if (mismatch !== 1'b0) begin fails++; $display("FAIL midreset mismatch: got %b want 0", mismatch); end
    total++; if (err_count !== 8'd0 || vec_count !== 8'd0) begin fails++; $display("FAIL midreset counters: got %0d/%0d want 0/0", err_count, vec_count); end
    total++; if (vec_ready !== 1'b1) begin fails++; $display("FAIL midreset vec_ready: got %b want 1", vec_ready); end
    @(negedge CLK);
    RESETN = 1'b1;
    q.delete();
  endtask

  task automatic test_empty_start();
    run_check("empty");
    leave_done("empty");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load(rand_vec($urandom_range(0, 2) == 0));
      run_check("random");
      leave_done("random");
    end
  endtask

`ifdef PARTIAL_BOUNDARY_MASK_EN
  task automatic test_mask();
    vec_t v;
    v = rand_vec(1'b0);
    v.exp  = v.exp ^ 4'b1000;
    v.mask = 4'b1000;
    load(v);
    run_check("mask_on");
    leave_done("mask_on");
    v.mask = 4'b0000;
    load(v);
    run_check("mask_off");
    leave_done("mask_off");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_full_wrap();
    test_reset_mid_run();
    test_empty_start();
    test_random();
`ifdef PARTIAL_BOUNDARY_MASK_EN
    test_mask();
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
